// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of the single UART transmitter.
// One of four byte-stream requesters holds the grant for a whole packet.
// A gap follows every packet. A requester that stalls mid-packet is dropped
// after HOLD_TIMEOUT idle cycles.
//
// Handshakes:
//   requester -> arbiter: req[i] stays high with stable data until req_ack[i]
//     pulses for one cycle. The next byte may be presented the cycle after.
//   arbiter -> transmitter: tx_start pulses for one cycle with tx_data valid.
//     The transmitter raises tx_busy on the following cycle and lowers it
//     once the frame is out.
// dbg_state and dbg_ptr expose the FSM state and round-robin pointer.
module uart_tx_arbiter #(
  parameter int          GAP_CYCLES   = 434,
  parameter logic [15:0] HOLD_TIMEOUT = 16'd60000
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ack,
  output logic        grant_valid,
  output logic [1:0]  grant_id,
  output logic        abort,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [2:0]  dbg_state,
  output logic [1:0]  dbg_ptr
);

  typedef enum logic [2:0] {
    ARB       = 3'd0,
    SEND      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam logic [15:0] GAP_W = GAP_CYCLES[15:0];

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  grant_id_q, grant_id_d;
  logic        grant_valid_q, grant_valid_d;
  logic        last_q, last_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic [3:0]  req_ack_q, req_ack_d;
  logic        abort_q, abort_d;

  logic        found;
  logic [1:0]  sel;
  logic [1:0]  idx;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Next-state and registered-output logic for the packet FSM.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    last_d        = last_q;
    hold_d        = hold_q;
    gap_d         = gap_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    req_ack_d     = 4'b0000;
    abort_d       = 1'b0;
    case (state_q)
      ARB: begin
        hold_d = 16'd0;
        if (found) begin
          grant_id_d    = sel;
          grant_valid_d = 1'b1;
          ptr_d         = sel;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (req[grant_id_q]) begin
          // Byte ready; it goes out only when the transmitter is idle.
          if (!tx_busy) begin
            tx_data_d  = req_data[{grant_id_q, 3'b000} +: 8];
            tx_start_d = 1'b1;
            req_ack_d  = 4'b0001 << grant_id_q;
            last_d     = req_last[grant_id_q];
            hold_d     = 16'd0;
            state_d    = WAIT_BUSY;
          end
        end else begin
          // Stalled requester: release the grant once the hold limit hits.
          hold_d = hold_q + 16'd1;
          if (hold_q + 16'd1 == HOLD_TIMEOUT) begin
            abort_d       = 1'b1;
            grant_valid_d = 1'b0;
            hold_d        = 16'd0;
            gap_d         = 16'd0;
            state_d       = GAP;
          end
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_valid_d = 1'b0;
            gap_d         = 16'd0;
            state_d       = GAP;
          end else begin
            state_d = SEND;
          end
        end
      end
      GAP: begin
        // GAP_CYCLES+1 cycles here, so GAP_CYCLES=0 still gives one cycle.
        if (gap_q == GAP_W) begin
          gap_d   = 16'd0;
          state_d = ARB;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q       <= ARB;
      ptr_q         <= 2'd3;
      grant_id_q    <= 2'd0;
      grant_valid_q <= 1'b0;
      last_q        <= 1'b0;
      hold_q        <= 16'd0;
      gap_q         <= 16'd0;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      req_ack_q     <= 4'b0000;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      last_q        <= last_d;
      hold_q        <= hold_d;
      gap_q         <= gap_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      req_ack_q     <= req_ack_d;
      abort_q       <= abort_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign abort       = abort_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign dbg_state   = state_q;
  assign dbg_ptr     = ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: four requester models, a transmitter model,
// a tx_start scoreboard and directed vector / corner-case sequences.
module tb_uart_tx_arbiter;

  localparam int          GAP   = 6;
  localparam logic [15:0] HOLD  = 16'd40;
  localparam int          FRAME = 10;

  // ---------------- clock / reset ----------------
  logic clk_50M = 1'b0;
  logic rst     = 1'b1;
  always #10 clk_50M = ~clk_50M;

  logic [3:0]  req      = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ack;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        abort;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [2:0]  dbg_state;
  logic [1:0]  dbg_ptr;

  uart_tx_arbiter #(.GAP_CYCLES(GAP), .HOLD_TIMEOUT(HOLD)) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ack    (req_ack),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .abort      (abort),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .dbg_state  (dbg_state),
    .dbg_ptr    (dbg_ptr)
  );

  // ---------------- transmitter model ----------------
  int   busy_cnt   = 0;
  logic force_busy = 1'b0;
  assign tx_busy = (busy_cnt != 0) || force_busy;

  always @(posedge clk_50M) begin
    if (rst)             busy_cnt <= 0;
    else if (tx_start)   busy_cnt <= FRAME;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];      // {id, byte} in expected transmit order
  logic [8:0] rq [4][$];     // per requester {last, byte}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Requester models and tx_start scoreboard, evaluated away from the edge.
  always @(negedge clk_50M) begin
    logic [9:0] e;
    if (tx_start) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tx_start", {24'd0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, e[7:0]});
        check("tx_grant_id", {30'd0, grant_id}, {30'd0, e[9:8]});
        check("tx_req_ack", {28'd0, req_ack}, {28'd0, 4'b0001 << e[9:8]});
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0) begin
        req[i]              = 1'b1;
        req_data[8*i +: 8]  = rq[i][0][7:0];
        req_last[i]         = rq[i][0][8];
      end else begin
        req[i]      = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [7:0] pkt_byte(input int v, input int id, input int k);
    return 8'((v * 16) + (id * 4) + k);
  endfunction

  task automatic push_pkt(input int id, input int len, input int v);
    for (int k = 0; k < len; k++) begin
      rq[id].push_back({(k == len - 1), pkt_byte(v, id, k)});
      exp_q.push_back({2'(id), pkt_byte(v, id, k)});
    end
  endtask

  task automatic push_raw(input int id, input logic [7:0] b, input logic last);
    rq[id].push_back({last, b});
    exp_q.push_back({2'(id), b});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || dbg_state != 3'd0) && n < 3000) begin
      @(negedge clk_50M);
      n++;
    end
    check(name, {31'd0, (exp_q.size() == 0 && dbg_state == 3'd0)}, 32'd1);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n = 0;
    while (dbg_state != s && n < 3000) begin
      @(negedge clk_50M);
      n++;
    end
    check(name, {29'd0, dbg_state}, {29'd0, s});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ack"},     {28'd0, req_ack},     32'd0);
    check({tag, "_tx_start"},    {31'd0, tx_start},    32'd0);
    check({tag, "_abort"},       {31'd0, abort},       32'd0);
    check({tag, "_grant_valid"}, {31'd0, grant_valid}, 32'd0);
    check({tag, "_grant_id"},    {30'd0, grant_id},    32'd0);
    check({tag, "_tx_data"},     {24'd0, tx_data},     32'd0);
    check({tag, "_ptr"},         {30'd0, dbg_ptr},     32'd3);
    check({tag, "_state"},       {29'd0, dbg_state},   32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0] mask;   // requesters loaded together
    logic [1:0] len;    // bytes per packet
    logic [7:0] order;  // expected grant order, entry j at [2j+1:2j]
    logic [2:0] cnt;    // number of packets
  } vec_t;

  vec_t vecs [7];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int strobes;
    vecs[0] = '{4'b0100, 2'd1, {2'd0, 2'd0, 2'd0, 2'd2}, 3'd1};
    vecs[1] = '{4'b1111, 2'd2, {2'd2, 2'd1, 2'd0, 2'd3}, 3'd4};
    vecs[2] = '{4'b0011, 2'd1, {2'd0, 2'd0, 2'd1, 2'd0}, 3'd2};
    vecs[3] = '{4'b1010, 2'd1, {2'd0, 2'd0, 2'd1, 2'd3}, 3'd2};
    vecs[4] = '{4'b0010, 2'd2, {2'd0, 2'd0, 2'd0, 2'd1}, 3'd1};
    vecs[5] = '{4'b1001, 2'd2, {2'd0, 2'd0, 2'd0, 2'd3}, 3'd2};
    vecs[6] = '{4'b1111, 2'd1, {2'd0, 2'd3, 2'd2, 2'd1}, 3'd4};

    repeat (3) @(negedge clk_50M);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk_50M);

    // Single requester: timing of grant, strobe, packet end and gap.
    push_raw(2, 8'hA5, 1'b1);
    n = 0;
    while (!grant_valid && n < 20) begin @(negedge clk_50M); n++; end
    check("single_grant_valid", {31'd0, grant_valid}, 32'd1);
    check("single_grant_id", {30'd0, grant_id}, 32'd2);
    check("single_no_early_strobe", {31'd0, tx_start}, 32'd0);
    @(negedge clk_50M);
    check("single_strobe", {31'd0, tx_start}, 32'd1);
    check("single_ack", {28'd0, req_ack}, 32'b0100);
    @(negedge clk_50M);
    check("single_strobe_one_cycle", {31'd0, tx_start}, 32'd0);
    check("single_ack_one_cycle", {28'd0, req_ack}, 32'd0);
    n = 2;
    while (grant_valid && n < 200) begin @(negedge clk_50M); n++; end
    check("single_packet_length", n, FRAME + 3);
    push_raw(0, 8'h3C, 1'b1);
    n = 0;
    while (!grant_valid && n < 200) begin @(negedge clk_50M); n++; end
    check("gap_to_next_grant", n, GAP + 2);
    check("gap_next_grant_id", {30'd0, grant_id}, 32'd0);
    wait_drain("single_drain");

    // Table-driven arbitration vectors.
    for (int v = 0; v < 7; v++) begin
      wait_state(3'd0, "vec_idle");
      for (int j = 0; j < int'(vecs[v].cnt); j++)
        push_pkt(int'(vecs[v].order[2*j +: 2]), int'(vecs[v].len), v);
      wait_drain($sformatf("vec%0d_drain", v));
    end

    // Stalled requester 1 is aborted; pending requester 3 goes next.
    wait_state(3'd0, "abort_idle");
    push_raw(1, 8'h11, 1'b0);
    push_raw(3, 8'h33, 1'b1);
    n = 0;
    while (!(dbg_state == 3'd1 && exp_q.size() == 1) && n < 500) begin
      @(negedge clk_50M); n++;
    end
    check("abort_send_reentry", {29'd0, dbg_state}, 32'd1);
    n = 0;
    while (!abort && n < 200) begin @(negedge clk_50M); n++; end
    check("abort_latency", n, int'(HOLD));
    check("abort_drops_grant", {31'd0, grant_valid}, 32'd0);
    @(negedge clk_50M);
    check("abort_one_cycle", {31'd0, abort}, 32'd0);
    wait_drain("abort_then_req3");

    // Transmitter held busy: no strobe until it goes idle, then one.
    wait_state(3'd0, "busy_idle");
    force_busy = 1'b1;
    push_raw(0, 8'h5A, 1'b1);
    wait_state(3'd1, "busy_in_send");
    strobes = 0;
    repeat (1000) begin
      @(negedge clk_50M);
      if (tx_start) strobes++;
    end
    check("busy_no_strobe", strobes, 0);
    force_busy = 1'b0;
    strobes = 0;
    repeat (40) begin
      @(negedge clk_50M);
      if (tx_start) strobes++;
    end
    check("busy_single_strobe", strobes, 1);
    wait_drain("busy_drain");

    // Reset in WAIT_DONE of a 3-byte packet.
    wait_state(3'd0, "rst_idle");
    push_raw(2, 8'h71, 1'b0);
    push_raw(2, 8'h72, 1'b0);
    push_raw(2, 8'h73, 1'b1);
    wait_state(3'd3, "rst_in_wait_done");
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) rq[i].delete();
    @(negedge clk_50M);
    check_reset_values("midpkt_rst");
    @(negedge clk_50M);
    rst = 1'b0;
    @(negedge clk_50M);
    for (int i = 0; i < 4; i++) push_pkt(i, 1, 9);
    wait_drain("post_rst_order");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
